// File: rtl/hsv_adj_ctrl.sv
// hsv_adj_ctrl: frame-synchronous config shadow/commit plus a 2-stage HSV
// adjust pipeline feeding the HSV-to-RGB converter.
module hsv_adj_ctrl #(
  parameter int HUE_RANGE = 360,
  parameter int GAIN_FRAC = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [8:0]  cfg_wdata,
  input  logic        vs,
  input  logic        hs,
  input  logic        de,
  input  logic [8:0]  i_hsv_h,
  input  logic [8:0]  i_hsv_s,
  input  logic [7:0]  i_hsv_v,
  output logic        o_vs,
  output logic        o_hs,
  output logic        o_de,
  output logic [8:0]  o_hsv_h,
  output logic [8:0]  o_hsv_s,
  output logic [7:0]  o_hsv_v,
  output logic        cfg_pending,
  output logic        commit_pulse,
  output logic [15:0] frame_cnt
);
  localparam logic [8:0] HUE_MAX   = 9'(HUE_RANGE - 1);
  localparam logic [9:0] HUE_MOD   = 10'(HUE_RANGE);
  localparam logic [7:0] UNITY     = 8'(1 << GAIN_FRAC);

  typedef enum logic {IDLE, PENDING} state_t;
  state_t r_state;

  logic       r_vs_q;
  logic [8:0] r_sh_hue, r_act_hue;
  logic [7:0] r_sh_sat, r_act_sat;
  logic [7:0] r_sh_val, r_act_val;
  logic       r_sh_en,  r_act_en;
  logic       r_commit;
  logic [15:0] r_frame;

  logic       w_vs_rise;
  logic [8:0] w_hue_wr;
  logic [8:0] w_hc;

  assign w_vs_rise    = vs & ~r_vs_q;
  assign w_hue_wr     = (cfg_wdata > HUE_MAX) ? HUE_MAX : cfg_wdata;
  assign w_hc         = (i_hsv_h > HUE_MAX) ? HUE_MAX : i_hsv_h;
  assign cfg_pending  = (r_state == PENDING);
  assign commit_pulse = r_commit;
  assign frame_cnt    = r_frame;

  // Commit FSM: writes land in shadow; active takes the pre-write shadow on vs_rise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_vs_q    <= 1'b0;
      r_commit  <= 1'b0;
      r_frame   <= 16'd0;
      r_sh_hue  <= 9'd0;  r_act_hue <= 9'd0;
      r_sh_sat  <= UNITY; r_act_sat <= UNITY;
      r_sh_val  <= UNITY; r_act_val <= UNITY;
      r_sh_en   <= 1'b0;  r_act_en  <= 1'b0;
    end else begin
      r_vs_q   <= vs;
      r_commit <= 1'b0;
      if (w_vs_rise) r_frame <= r_frame + 16'd1;
      case (r_state)
        IDLE: if (cfg_wr) r_state <= PENDING;
        PENDING: begin
          if (w_vs_rise) begin
            r_act_hue <= r_sh_hue;
            r_act_sat <= r_sh_sat;
            r_act_val <= r_sh_val;
            r_act_en  <= r_sh_en;
            r_commit  <= 1'b1;
            // a write colliding with the commit keeps the FSM pending
            if (!cfg_wr) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (cfg_wr) begin
        case (cfg_addr)
          2'd0: r_sh_hue <= w_hue_wr;
          2'd1: r_sh_sat <= cfg_wdata[7:0];
          2'd2: r_sh_val <= cfg_wdata[7:0];
          default: r_sh_en <= cfg_wdata[0];
        endcase
      end
    end
  end

  logic [9:0]  r_s1_hsum;
  logic [16:0] r_s1_smul;
  logic [15:0] r_s1_vmul;
  logic [8:0]  r_s1_h, r_s1_s;
  logic [7:0]  r_s1_v;
  logic        r_s1_en;
  logic [2:0]  r_sync_s1;

  // Stage 1: clamp + add hue, multiply gains, keep raw copies for bypass
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_hsum <= '0; r_s1_smul <= '0; r_s1_vmul <= '0;
      r_s1_h    <= '0; r_s1_s    <= '0; r_s1_v    <= '0;
      r_s1_en   <= 1'b0;
      r_sync_s1 <= '0;
    end else begin
      r_s1_hsum <= {1'b0, w_hc} + {1'b0, r_act_hue};
      r_s1_smul <= {8'd0, i_hsv_s} * {9'd0, r_act_sat};
      r_s1_vmul <= {8'd0, i_hsv_v} * {8'd0, r_act_val};
      r_s1_h    <= i_hsv_h;
      r_s1_s    <= i_hsv_s;
      r_s1_v    <= i_hsv_v;
      r_s1_en   <= r_act_en;
      r_sync_s1 <= {vs, hs, de};
    end
  end

  logic [8:0]  w_h;
  logic [16:0] w_s_sh;
  logic [15:0] w_v_sh;
  logic [8:0]  w_s;
  logic [7:0]  w_v;

  assign w_h    = 9'((r_s1_hsum >= HUE_MOD) ? (r_s1_hsum - HUE_MOD) : r_s1_hsum);
  assign w_s_sh = r_s1_smul >> GAIN_FRAC;
  assign w_v_sh = r_s1_vmul >> GAIN_FRAC;
  assign w_s    = (w_s_sh > 17'd255) ? 9'd255 : {1'b0, w_s_sh[7:0]};
  assign w_v    = (w_v_sh > 16'd255) ? 8'd255 : w_v_sh[7:0];

  // Stage 2: wrap hue, saturate gains, or bypass raw input when disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      o_hsv_h <= '0; o_hsv_s <= '0; o_hsv_v <= '0;
      {o_vs, o_hs, o_de} <= 3'b000;
    end else begin
      o_hsv_h <= r_s1_en ? w_h : r_s1_h;
      o_hsv_s <= r_s1_en ? w_s : r_s1_s;
      o_hsv_v <= r_s1_en ? w_v : r_s1_v;
      {o_vs, o_hs, o_de} <= r_sync_s1;
    end
  end
endmodule

// File: tb/tb_hsv_adj_ctrl.sv
// tb_hsv_adj_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the shadow/commit rules and pixel math.
module tb_hsv_adj_ctrl;
  logic        clk = 1'b0;
  logic        reset, cfg_wr, vs, hs, de;
  logic [1:0]  cfg_addr;
  logic [8:0]  cfg_wdata, ih, is;
  logic [7:0]  iv;
  logic        o_vs, o_hs, o_de, cfg_pending, commit_pulse;
  logic [8:0]  o_hsv_h, o_hsv_s;
  logic [7:0]  o_hsv_v;
  logic [15:0] frame_cnt;

  int nvec = 0, nerr = 0;

  hsv_adj_ctrl dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .vs(vs), .hs(hs), .de(de),
    .i_hsv_h(ih), .i_hsv_s(is), .i_hsv_v(iv),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de),
    .o_hsv_h(o_hsv_h), .o_hsv_s(o_hsv_s), .o_hsv_v(o_hsv_v),
    .cfg_pending(cfg_pending), .commit_pulse(commit_pulse), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // model: settings as {hue, sat, val, en}
  int  sh_hue, sh_sat, sh_val, act_hue, act_sat, act_val;
  bit  sh_en, act_en, m_pend, m_pulse, m_vsq;
  int  m_frame;
  logic [28:0] e1, eo;  // {vs,hs,de,h,s,v}: stage-1 and output expectations

  function automatic logic [25:0] adj(int h, int s, int v, int off, int sg, int vg, bit en);
    int hh, ss, vv;
    if (!en) return {9'(h), 9'(s), 8'(v)};
    hh = ((h > 359) ? 359 : h) + off;
    if (hh >= 360) hh -= 360;
    ss = (s * sg) / 64; if (ss > 255) ss = 255;
    vv = (v * vg) / 64; if (vv > 255) vv = 255;
    return {9'(hh), 9'(ss), 8'(vv)};
  endfunction

  task automatic tick();
    bit rise;
    @(posedge clk);
    if (reset) begin
      sh_hue = 0; sh_sat = 64; sh_val = 64; sh_en = 0;
      act_hue = 0; act_sat = 64; act_val = 64; act_en = 0;
      m_pend = 0; m_pulse = 0; m_vsq = 0; m_frame = 0; e1 = '0; eo = '0;
    end else begin
      rise  = vs && !m_vsq;
      m_vsq = vs;
      eo = e1;
      e1 = {vs, hs, de, adj(ih, is, iv, act_hue, act_sat, act_val, act_en)};
      m_pulse = rise && m_pend;
      if (m_pulse) begin
        act_hue = sh_hue; act_sat = sh_sat; act_val = sh_val; act_en = sh_en;
      end
      if (rise) m_frame = (m_frame + 1) % 65536;
      if (cfg_wr) m_pend = 1; else if (m_pulse) m_pend = 0;
      if (cfg_wr) case (cfg_addr)
        2'd0: sh_hue = (cfg_wdata > 359) ? 359 : int'(cfg_wdata);
        2'd1: sh_sat = int'(cfg_wdata[7:0]);
        2'd2: sh_val = int'(cfg_wdata[7:0]);
        default: sh_en = cfg_wdata[0];
      endcase
    end
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [8:0] d);
    cfg_wr = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr = 0;
  endtask

  task automatic test_reset();
    reset = 1; cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0;
    vs = 1; hs = 1; de = 1; ih = 9'd123; is = 9'd45; iv = 8'd67;
    repeat (3) tick();
    nvec++;
    if ({o_hsv_h, o_hsv_s, o_hsv_v, o_vs, o_hs, o_de, frame_cnt, cfg_pending, commit_pulse} !== '0) begin
      nerr++;
      $display("FAIL reset_state: got h=%0d s=%0d v=%0d sync=%b frame=%0d pend=%b pulse=%b, want all 0",
               o_hsv_h, o_hsv_s, o_hsv_v, {o_vs, o_hs, o_de}, frame_cnt, cfg_pending, commit_pulse);
    end
    vs = 0; hs = 0; de = 0;
    reset = 0;
    tick(); tick();
  endtask

  task automatic test_passthrough();
    ih = 9'd200; is = 9'd300; iv = 8'd100; de = 1;
    tick();
    nvec++;
    if (o_de !== 1'b0) begin nerr++; $display("FAIL pass_de_lag: got %b want 0", o_de); end
    tick();
    nvec++;
    if ({o_hsv_h, o_hsv_s, o_hsv_v, o_de} !== {9'd200, 9'd300, 8'd100, 1'b1}) begin
      nerr++;
      $display("FAIL passthrough: got %0d/%0d/%0d de=%b want 200/300/100 de=1", o_hsv_h, o_hsv_s, o_hsv_v, o_de);
    end
    de = 0;
  endtask

  task automatic test_commit();
    int f0;
    write(2'd0, 9'd100);
    nvec++;
    if (cfg_pending !== 1'b1) begin nerr++; $display("FAIL commit_pending: got %b want 1", cfg_pending); end
    write(2'd1, 9'd32); write(2'd2, 9'd128); write(2'd3, 9'd1);
    ih = 9'd300; is = 9'd200; iv = 8'd100;
    tick(); tick();
    nvec++;
    if ({o_hsv_h, o_hsv_s, o_hsv_v, cfg_pending} !== {9'd300, 9'd200, 8'd100, 1'b1}) begin
      nerr++;
      $display("FAIL commit_before_vs: got %0d/%0d/%0d pend=%b want 300/200/100 pend=1", o_hsv_h, o_hsv_s, o_hsv_v, cfg_pending);
    end
    f0 = frame_cnt;
    vs = 1; tick();
    nvec++;
    if ({commit_pulse, cfg_pending, frame_cnt} !== {1'b1, 1'b0, 16'(f0 + 1)}) begin
      nerr++;
      $display("FAIL commit_edge: got pulse=%b pend=%b frame=%0d want 1 0 %0d", commit_pulse, cfg_pending, frame_cnt, f0 + 1);
    end
    tick();
    nvec++;
    if (commit_pulse !== 1'b0) begin nerr++; $display("FAIL commit_pulse_width: got %b want 0", commit_pulse); end
    tick();
    nvec++;
    if ({o_hsv_h, o_hsv_s, o_hsv_v} !== {9'd40, 9'd100, 8'd200}) begin
      nerr++;
      $display("FAIL commit_after: got %0d/%0d/%0d want 40/100/200", o_hsv_h, o_hsv_s, o_hsv_v);
    end
    vs = 0; tick();
  endtask

  task automatic test_saturate();
    write(2'd0, 9'd400); write(2'd1, 9'd255); write(2'd2, 9'd255);
    vs = 1; tick(); vs = 0;
    ih = 9'd359; is = 9'd200; iv = 8'd200;
    tick(); tick();
    nvec++;
    if ({o_hsv_h, o_hsv_s, o_hsv_v} !== {9'd358, 9'd255, 8'd255}) begin
      nerr++;
      $display("FAIL saturate: got %0d/%0d/%0d want 358/255/255", o_hsv_h, o_hsv_s, o_hsv_v);
    end
    ih = 9'd400; is = 9'd10; iv = 8'd3;
    tick(); tick();
    nvec++;
    if ({o_hsv_h, o_hsv_s, o_hsv_v} !== {9'd358, 9'd39, 8'd11}) begin
      nerr++;
      $display("FAIL hue_clamp: got %0d/%0d/%0d want 358/39/11", o_hsv_h, o_hsv_s, o_hsv_v);
    end
  endtask

  task automatic test_same_cycle();
    write(2'd0, 9'd50);
    vs = 1; cfg_wr = 1; cfg_addr = 2'd0; cfg_wdata = 9'd80;
    tick();
    cfg_wr = 0;
    nvec++;
    if ({commit_pulse, cfg_pending} !== 2'b11) begin
      nerr++;
      $display("FAIL collide_state: got pulse=%b pend=%b want 1 1", commit_pulse, cfg_pending);
    end
    ih = 9'd0;
    tick(); tick();
    nvec++;
    if (o_hsv_h !== 9'd50) begin nerr++; $display("FAIL collide_active: got h=%0d want 50", o_hsv_h); end
    vs = 0; tick(); vs = 1; tick(); tick(); tick();
    nvec++;
    if ({o_hsv_h, cfg_pending} !== {9'd80, 1'b0}) begin
      nerr++;
      $display("FAIL collide_next: got h=%0d pend=%b want 80 0", o_hsv_h, cfg_pending);
    end
    vs = 0; tick();
  endtask

  task automatic test_reset_pending();
    write(2'd0, 9'd10);
    vs = 1; reset = 1; tick(); tick(); reset = 0;
    nvec++;
    if ({o_hsv_h, o_hsv_s, o_hsv_v, frame_cnt, cfg_pending} !== '0) begin
      nerr++;
      $display("FAIL rst_pend: got h=%0d s=%0d v=%0d frame=%0d pend=%b want 0", o_hsv_h, o_hsv_s, o_hsv_v, frame_cnt, cfg_pending);
    end
    tick();
    nvec++;
    if ({commit_pulse, frame_cnt} !== {1'b0, 16'd1}) begin
      nerr++;
      $display("FAIL rst_first_rise: got pulse=%b frame=%0d want 0 1", commit_pulse, frame_cnt);
    end
    vs = 0; write(2'd3, 9'd1); vs = 1; tick(); vs = 0;
    ih = 9'd100; is = 9'd100; iv = 8'd100;
    tick(); tick();
    nvec++;
    if ({o_hsv_h, o_hsv_s, o_hsv_v} !== {9'd100, 9'd100, 8'd100}) begin
      nerr++;
      $display("FAIL rst_unity: got %0d/%0d/%0d want 100/100/100", o_hsv_h, o_hsv_s, o_hsv_v);
    end
  endtask

  task automatic test_vs_hold();
    int f0;
    vs = 0; tick();
    f0 = frame_cnt;
    vs = 1; repeat (20) tick();
    nvec++;
    if (frame_cnt !== 16'(f0 + 1)) begin nerr++; $display("FAIL vs_hold: got %0d want %0d", frame_cnt, f0 + 1); end
    vs = 0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 499) == 0);
      cfg_wr    = ($urandom_range(0, 3) == 0);
      cfg_addr  = 2'($urandom);
      cfg_wdata = 9'($urandom);
      if ($urandom_range(0, 19) == 0) vs = ~vs;
      hs = 1'($urandom); de = 1'($urandom);
      ih = 9'($urandom); is = 9'($urandom); iv = 8'($urandom);
      tick();
      nvec++;
      if ({o_vs, o_hs, o_de, o_hsv_h, o_hsv_s, o_hsv_v} !== eo) begin
        nerr++;
        $display("FAIL rand_pixel[%0d]: got %h want %h", i, {o_vs, o_hs, o_de, o_hsv_h, o_hsv_s, o_hsv_v}, eo);
      end
      nvec++;
      if ({cfg_pending, commit_pulse, frame_cnt} !== {m_pend, m_pulse, 16'(m_frame)}) begin
        nerr++;
        $display("FAIL rand_ctrl[%0d]: got pend=%b pulse=%b frame=%0d want %b %b %0d",
                 i, cfg_pending, commit_pulse, frame_cnt, m_pend, m_pulse, m_frame);
      end
    end
    reset = 0; cfg_wr = 0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_commit();
    test_saturate();
    test_same_cycle();
    test_reset_pending();
    test_vs_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
